// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO and send sequencer feeding a UART transmitter, with a programmable idle gap between frames.
// Optional sticky overflow flag with clear input: define TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo_feeder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic          CLOCK,
    input  logic          RST,
    input  logic          WR_En,
    input  logic [7:0]    WR_Data,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Level,
    output logic [7:0]    TX_Data,
    output logic          TX_En_Sig,
    input  logic          TX_Done_Sig,
`ifdef TX_FIFO_OVERFLOW_EN
    input  logic          Ovf_Clr,
    output logic          Overflow,
`endif
    output logic          Busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     gap_cnt;
    logic            wr_ok;
    logic            pop;
    logic            done_ok;
    logic            gap_last;
    logic            tx_en_next;

    assign Full     = (Level == (AW+1)'(DEPTH));
    assign Empty    = (Level == '0);
    assign wr_ok    = WR_En && !Full;
    // Done only completes a frame once the request is actually up, so a Done
    // still held from the previous frame cannot retire a freshly popped byte.
    assign done_ok  = TX_Done_Sig && TX_En_Sig;
    assign gap_last = (gap_cnt == GAP_LAST);

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!Empty) state_next = SEND;
            SEND: if (done_ok) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (gap_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop        = (state == IDLE) && !Empty;
        tx_en_next = (state == SEND) && !done_ok;
        Busy       = (state != IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= WR_Data;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Level     <= '0;
            gap_cnt   <= '0;
            TX_Data   <= '0;
            TX_En_Sig <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                TX_Data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({wr_ok, pop})
                2'b10:   Level <= Level + (AW+1)'(1);
                2'b01:   Level <= Level - (AW+1)'(1);
                default: Level <= Level;
            endcase
            TX_En_Sig <= tx_en_next;
            gap_cnt   <= ((state == GAP) && !gap_last) ? gap_cnt + 16'd1 : '0;
        end
    end

`ifdef TX_FIFO_OVERFLOW_EN
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            Overflow <= 1'b0;
        end else if (WR_En && Full) begin
            Overflow <= 1'b1;
        end else if (Ovf_Clr) begin
            Overflow <= 1'b0;
        end
    end
`endif

endmodule
